fir_decim_serial: RTL

//  - Consumes the 128 kHz, 24-bit test/ADC sample stream (one in_valid strobe per 196 clk @ 25 MHz)
//    and produces an anti-aliased, decimated stream (DECIM=4 -> 32 kHz).
//  - Time-multiplexed single-MAC FIR: one tap per clk, runs once per DECIM input samples.
//  - Sits directly downstream of test_signal_128k / ADC capture, upstream of output formatting.

---
 rtl/fir_decim_serial_if.sv | 29 ++
 rtl/fir_decim_serial.sv | 117 +++++++++++
 2 files changed

// File: rtl/fir_decim_serial_if.sv
// Sample/coefficient/result bundle of the serial decimating FIR.
// master = upstream stimulus and consumer, slave = the filter.
interface fir_decim_serial_if #(
    parameter int DATA_W = 24,
    parameter int COEF_W = 18,
    parameter int TAPS   = 32
);
    localparam int AW = $clog2(TAPS);

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     busy;
    logic                     overrun;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_wdata,
        input  out_valid, out_data, busy, overrun
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_wdata,
        output out_valid, out_data, busy, overrun
    );
endinterface

// File: rtl/fir_decim_serial.sv
// Serial single-MAC decimating FIR: one tap per clock, one MAC pass per DECIM accepted samples.
// Circular delay line and coefficient bank are register arrays; output is rounded and saturated.
module fir_decim_serial #(
    parameter int DATA_W = 24,
    parameter int COEF_W = 18,
    parameter int TAPS   = 32,
    parameter int DECIM  = 4,
    parameter int SHIFT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fir_decim_serial_if.slave bus
);
    localparam int PW     = $clog2(TAPS);
    localparam int DW     = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + PW;

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(64'sd1 <<< (DATA_W - 1)));

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] dline [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            tap;
    logic [PW-1:0]            rd_ptr;
    logic [DW-1:0]            dec_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] tap_data;
    logic signed [PROD_W-1:0] tap_coef;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [DATA_W-1:0] sat;

    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     busy;
    logic                     overrun;

    // wr_ptr already points past the triggering sample, so x[n-k] sits at wr_ptr-1-k.
    assign rd_ptr   = wr_ptr - PW'(1) - tap;
    assign tap_data = PROD_W'(dline[rd_ptr]);
    assign tap_coef = PROD_W'(coef[tap]);
    assign prod     = tap_data * tap_coef;
    assign rounded  = (acc + HALF) >>> SHIFT;

    always_comb begin
        if (rounded > OUT_MAX)
            sat = OUT_MAX[DATA_W-1:0];
        else if (rounded < OUT_MIN)
            sat = OUT_MIN[DATA_W-1:0];
        else
            sat = rounded[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            tap       <= '0;
            dec_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (bus.in_valid && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.coef_we)
                        coef[bus.coef_addr] <= bus.coef_wdata;
                    if (bus.in_valid) begin
                        dline[wr_ptr] <= bus.in_data;
                        wr_ptr        <= wr_ptr + 1'b1;
                        if (dec_cnt == DW'(DECIM - 1)) begin
                            dec_cnt <= '0;
                            tap     <= '0;
                            busy    <= 1'b1;
                            state   <= MAC;
                        end else begin
                            dec_cnt <= dec_cnt + 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc <= ((tap == '0) ? '0 : acc) + ACC_W'(prod);
                    tap <= tap + 1'b1;
                    if (tap == PW'(TAPS - 1))
                        state <= ROUND;
                end
                ROUND: begin
                    out_data  <= sat;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.busy      = busy;
    assign bus.overrun   = overrun;
endmodule
